audio_serial_rx: RTL and testbench

Parametrised stereo audio serial receiver for the pedal datapath. It replaces the single-channel, BCLK-clocked deserialiser between the codec ADC and `dsp_subsystem`. The block runs entirely on the system clock and oversamples BCLK, LRCLK and ADC data. It delivers both channels plus a mono mix with a one-cycle valid strobe, supports left-justified and I2S framing at configurable word width, and flags malformed frames.

---
 rtl/audio_serial_rx.sv | 205 ++++++++++++++++++++
 tb/tb_audio_serial_rx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_serial_rx.sv
`default_nettype none
// =============================================================================
// audio_serial_rx : oversampled left-justified / I2S stereo receiver with mono mix
// Revision 1.0
// =============================================================================
module audio_serial_rx #(
   parameter int DATA_WIDTH  = 16,
   parameter int I2S_MODE    = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  bclk,
   input  logic                  lrclk,
   input  logic                  in_data,
   input  logic                  enable,
   input  logic                  clear_error,
   output logic [DATA_WIDTH-1:0] left_sample,
   output logic [DATA_WIDTH-1:0] right_sample,
   output logic [DATA_WIDTH-1:0] mono_sample,
   output logic                  sample_valid,
   output logic                  frame_error
);
   localparam int               CNT_W      = 6;
   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DATA_WIDTH);
   localparam logic             IS_I2S     = (I2S_MODE != 0);
   localparam logic             LEFT_LEVEL = (I2S_MODE == 0);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_PAD   = 2'd2;

   logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
   logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d;
   logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
   logic                   bclk_s, lr_s, din_s;

   logic bclk_prev_q, bclk_prev_d, lr_prev_q, lr_prev_d, lr_seen_q, lr_seen_d;
   logic evt_q, evt_d, bnd_q, bnd_d, new_left_q, new_left_d, bit_q, bit_d;

   logic [1:0]            state_q, state_d;
   logic                  ch_q, ch_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_next;
   logic [DATA_WIDTH-1:0] sh_q, sh_d, sh_next;
   logic [DATA_WIDTH-1:0] left_word_q, left_word_d;
   logic                  left_ok_q, left_ok_d;
   logic [DATA_WIDTH-1:0] left_q, left_d, right_q, right_d, mono_q, mono_d;
   logic                  valid_q, valid_d, err_q, err_d;
   logic [DATA_WIDTH:0]   mono_sum;

   logic go, shift_cur, done_cur, short_word, start_left, start_right, wait_right;

   assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
   assign lr_s   = lr_sync_q[SYNC_STAGES-1];
   assign din_s  = din_sync_q[SYNC_STAGES-1];

   // Bit events are registered once so lrclk/data travel with their own bclk edge.
   always_comb begin
      bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], bclk};
      lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], lrclk};
      din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], in_data};
      bclk_prev_d = bclk_s;
      evt_d       = bclk_s & ~bclk_prev_q;
      bnd_d       = evt_d & lr_seen_q & (lr_s != lr_prev_q);
      new_left_d  = (lr_s == LEFT_LEVEL);
      bit_d       = din_s;
      lr_prev_d   = evt_d ? lr_s : lr_prev_q;
      lr_seen_d   = lr_seen_q | evt_d;
   end

   assign go          = enable & evt_q;
   assign sh_next     = {sh_q[DATA_WIDTH-2:0], bit_q};
   assign cnt_next    = cnt_q + 1'b1;
   assign shift_cur   = go & (state_q == ST_SHIFT) & (~bnd_q | IS_I2S);
   assign done_cur    = shift_cur & (cnt_next == CNT_FULL);
   assign short_word  = go & bnd_q & (state_q != ST_IDLE) & (cnt_q != CNT_FULL) & ~done_cur;
   assign start_left  = go & bnd_q & new_left_q;
   assign start_right = go & bnd_q & ~new_left_q & (state_q != ST_IDLE) & ~short_word & ~ch_q;
   assign wait_right  = go & bnd_q & ~new_left_q & (state_q != ST_IDLE) & ~start_right;
   assign mono_sum    = {left_word_q[DATA_WIDTH-1], left_word_q} + {sh_next[DATA_WIDTH-1], sh_next};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = ST_IDLE;
      end else if (start_left || start_right) begin
         state_d = ST_SHIFT;
      end else if (wait_right || done_cur) begin
         state_d = ST_PAD;
      end
   end

   // After a short word into right, PAD parks as a "full" right channel with no
   // held left word, so the next left boundary restarts cleanly and silently.
   always_comb begin
      ch_d        = ch_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      left_word_d = left_word_q;
      left_ok_d   = left_ok_q;
      left_d      = left_q;
      right_d     = right_q;
      mono_d      = mono_q;
      valid_d     = 1'b0;
      err_d       = err_q & ~clear_error;
      if (shift_cur) begin
         sh_d  = sh_next;
         cnt_d = cnt_next;
      end
      if (done_cur && !ch_q) begin
         left_word_d = sh_next;
         left_ok_d   = 1'b1;
      end
      if (done_cur && ch_q && left_ok_q) begin
         left_d    = left_word_q;
         right_d   = sh_next;
         mono_d    = mono_sum[DATA_WIDTH:1];
         valid_d   = 1'b1;
         left_ok_d = 1'b0;
      end
      if (short_word) begin
         err_d     = 1'b1;
         left_ok_d = 1'b0;
      end
      if (start_left) begin
         left_ok_d = 1'b0;
      end
      if (start_left || start_right) begin
         ch_d  = start_right;
         cnt_d = IS_I2S ? '0 : CNT_W'(1);
         sh_d  = IS_I2S ? '0 : {{(DATA_WIDTH-1){1'b0}}, bit_q};
      end
      if (wait_right) begin
         ch_d      = 1'b1;
         cnt_d     = CNT_FULL;
         left_ok_d = 1'b0;
      end
      if (!enable) begin
         cnt_d     = '0;
         left_ok_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bclk_sync_q <= '0;
         lr_sync_q   <= '0;
         din_sync_q  <= '0;
         bclk_prev_q <= 1'b0;
         lr_prev_q   <= 1'b0;
         lr_seen_q   <= 1'b0;
         evt_q       <= 1'b0;
         bnd_q       <= 1'b0;
         new_left_q  <= 1'b0;
         bit_q       <= 1'b0;
         ch_q        <= 1'b0;
         cnt_q       <= '0;
         sh_q        <= '0;
         left_word_q <= '0;
         left_ok_q   <= 1'b0;
         left_q      <= '0;
         right_q     <= '0;
         mono_q      <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         bclk_sync_q <= bclk_sync_d;
         lr_sync_q   <= lr_sync_d;
         din_sync_q  <= din_sync_d;
         bclk_prev_q <= bclk_prev_d;
         lr_prev_q   <= lr_prev_d;
         lr_seen_q   <= lr_seen_d;
         evt_q       <= evt_d;
         bnd_q       <= bnd_d;
         new_left_q  <= new_left_d;
         bit_q       <= bit_d;
         ch_q        <= ch_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         left_word_q <= left_word_d;
         left_ok_q   <= left_ok_d;
         left_q      <= left_d;
         right_q     <= right_d;
         mono_q      <= mono_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

   assign left_sample  = left_q;
   assign right_sample = right_q;
   assign mono_sample  = mono_q;
   assign sample_valid = valid_q;
   assign frame_error  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_serial_rx.sv
`default_nettype none
// Two receivers (left-justified/16-bit and I2S/24-bit) fed random framed streams;
// expected words come from an arithmetic frame model through a scoreboard.
module tb_audio_serial_rx;
   localparam int DW0 = 16;
   localparam int DW1 = 24;
   localparam int SS0 = 2;
   localparam int SS1 = 3;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic           reset_n, enable, clear_error;
   logic [1:0]     bclk, lrclk, din;
   logic [DW0-1:0] l0, r0, m0;
   logic           v0, e0;
   logic [DW1-1:0] l1, r1, m1;
   logic           v1, e1;

   typedef struct {
      logic [31:0] l;
      logic [31:0] r;
      logic [31:0] m;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   lat0[$];
   int   lat1[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic pend_bit = 1'b0;
   bit   pend_tag = 1'b0;
   bit   cnt_err_en = 1'b0;
   int   err_cycles = 0;
   logic pv0 = 1'b0;
   logic pv1 = 1'b0;

   audio_serial_rx #(.DATA_WIDTH(DW0), .I2S_MODE(0), .SYNC_STAGES(SS0)) u_lj (
      .clock(clk), .reset_n(reset_n), .bclk(bclk[0]), .lrclk(lrclk[0]), .in_data(din[0]),
      .enable(enable), .clear_error(clear_error), .left_sample(l0), .right_sample(r0),
      .mono_sample(m0), .sample_valid(v0), .frame_error(e0));

   audio_serial_rx #(.DATA_WIDTH(DW1), .I2S_MODE(1), .SYNC_STAGES(SS1)) u_i2s (
      .clock(clk), .reset_n(reset_n), .bclk(bclk[1]), .lrclk(lrclk[1]), .in_data(din[1]),
      .enable(enable), .clear_error(clear_error), .left_sample(l1), .right_sample(r1),
      .mono_sample(m1), .sample_valid(v1), .frame_error(e1));

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string nm, input int u, input logic [95:0] got, input logic [95:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s u%0d: got %h, required %h", nm, u, got, exp);
      end
   endtask

   // Floor of (L+R)/2 over the signed values, wrapped back to DW bits.
   function automatic exp_t model(input int dw, input logic [31:0] l, input logic [31:0] r);
      exp_t   e;
      longint full, ls, rs, s, m;
      full = longint'(1) << dw;
      ls = longint'(l);
      rs = longint'(r);
      if (ls >= full / 2) ls = ls - full;
      if (rs >= full / 2) rs = rs - full;
      s = ls + rs;
      if (s >= 0) m = s / 2;
      else        m = -((-s + 1) / 2);
      if (m < 0) m = m + full;
      e.l = l;
      e.r = r;
      e.m = 32'(m);
      return e;
   endfunction

   task automatic check_out(input int u, input logic [31:0] l, input logic [31:0] r,
                            input logic [31:0] m, input logic prev);
      exp_t e;
      int   t0;
      int   want_lat;
      want_lat = (u == 0) ? SS0 + 2 : SS1 + 2;
      cmp("valid_width", u, 96'(prev), 96'(0));
      total++;
      if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
         bad++;
         $display("FAIL unexpected_valid u%0d: got left=%h right=%h, required no output", u, l, r);
         return;
      end
      if (u == 0) begin
         e  = q0.pop_front();
         t0 = (lat0.size() > 0) ? lat0.pop_front() : -1000;
      end else begin
         e  = q1.pop_front();
         t0 = (lat1.size() > 0) ? lat1.pop_front() : -1000;
      end
      cmp("left", u, 96'(l), 96'(e.l));
      cmp("right", u, 96'(r), 96'(e.r));
      cmp("mono", u, 96'(m), 96'(e.m));
      cmp("latency", u, 96'(cyc - t0), 96'(want_lat));
   endtask

   always @(negedge clk) begin
      if (v0) check_out(0, 32'(l0), 32'(r0), 32'(m0), pv0);
      if (v1) check_out(1, 32'(l1), 32'(r1), 32'(m1), pv1);
      if (cnt_err_en && e0) err_cycles++;
      pv0 <= v0;
      pv1 <= v1;
   end

   // The I2S stream carries each data bit one bclk after its slot position.
   task automatic drive_bit(input int u, input logic lr, input logic d, input bit tag);
      int   lo, hi;
      logic dout;
      bit   tout;
      lo = $urandom_range(3, 5);
      hi = $urandom_range(3, 5);
      if (u == 1) begin
         dout     = pend_bit;
         tout     = pend_tag;
         pend_bit = d;
         pend_tag = tag;
      end else begin
         dout = d;
         tout = tag;
      end
      bclk[u]  = 1'b0;
      lrclk[u] = lr;
      din[u]   = dout;
      repeat (lo) @(posedge clk);
      #1;
      bclk[u] = 1'b1;
      if (tout) begin
         if (u == 0) lat0.push_back(cyc);
         else        lat1.push_back(cyc);
      end
      repeat (hi) @(posedge clk);
      #1;
   endtask

   task automatic send_slot(input int u, input bit left, input logic [31:0] word,
                            input int dw, input int slot_len, input bit tag_lsb);
      logic lr;
      logic d;
      lr = (u == 0) ? left : ~left;
      for (int i = 0; i < slot_len; i++) begin
         if (i < dw) d = word[dw-1-i];
         else        d = 1'($urandom_range(0, 1));
         drive_bit(u, lr, d, tag_lsb && (i == dw - 1));
      end
   endtask

   task automatic send_frame(input int u, input logic [31:0] l, input logic [31:0] r,
                             input int sl, input int sr, input bit want);
      int dw;
      bit ok;
      dw = (u == 0) ? DW0 : DW1;
      ok = want && (sl >= dw) && (sr >= dw);
      if (ok) begin
         if (u == 0) q0.push_back(model(dw, l, r));
         else        q1.push_back(model(dw, l, r));
      end
      send_slot(u, 1'b1, l, dw, sl, 1'b0);
      send_slot(u, 1'b0, r, dw, sr, ok);
   endtask

   task automatic tail(input int u);
      drive_bit(u, (u == 0) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rnd(input int dw);
      logic [31:0] mask;
      mask = (32'(1) << dw) - 32'(1);
      return $urandom & mask;
   endfunction

   initial begin
      #(80000 * 20);
      $display("FAIL watchdog: got no end of test, required finish within budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n     = 1'b0;
      enable      = 1'b1;
      clear_error = 1'b0;
      bclk        = '0;
      lrclk       = '0;
      din         = '0;
      repeat (4) @(posedge clk);
      #1;
      cmp("reset_state", 0, 96'({l0, r0, m0, v0, e0}), 96'(0));
      cmp("reset_state", 1, 96'({l1, r1, m1, v1, e1}), 96'(0));
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Left-justified, 16-bit: directed frame then random slot widths.
      send_slot(0, 1'b0, 32'h0, DW0, 4, 1'b0);
      send_frame(0, 32'h1234, 32'hFEDC, 16, 16, 1'b1);
      tail(0);
      cmp("frame_error_clean", 0, 96'(e0), 96'(0));
      repeat (6) send_frame(0, rnd(DW0), rnd(DW0), $urandom_range(16, 20), $urandom_range(16, 20), 1'b1);
      tail(0);

      // Truncated left slot, then a good frame; then clear.
      send_frame(0, rnd(DW0), rnd(DW0), 12, 16, 1'b1);
      send_frame(0, 32'h0001, 32'h0003, 16, 16, 1'b1);
      tail(0);
      cmp("frame_error_set", 0, 96'(e0), 96'(1));
      clear_error = 1'b1;
      @(posedge clk);
      #1;
      clear_error = 1'b0;
      cmp("frame_error_clear", 0, 96'(e0), 96'(0));

      // clear_error held across a new short word: the flag must still show.
      err_cycles  = 0;
      cnt_err_en  = 1'b1;
      clear_error = 1'b1;
      send_frame(0, rnd(DW0), rnd(DW0), 12, 16, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      cnt_err_en  = 1'b0;
      clear_error = 1'b0;
      cmp("error_beats_clear", 0, 96'(err_cycles), 96'(1));
      cmp("error_cleared_after", 0, 96'(e0), 96'(0));

      // Reset halfway through the right slot.
      send_slot(0, 1'b1, rnd(DW0), DW0, 16, 1'b0);
      send_slot(0, 1'b0, rnd(DW0), DW0, 8, 1'b0);
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      cmp("midframe_reset", 0, 96'({l0, r0, m0, v0, e0}), 96'(0));
      reset_n = 1'b1;
      send_slot(0, 1'b0, rnd(DW0), DW0, 8, 1'b0);
      send_frame(0, 32'h00AA, 32'h0055, 16, 16, 1'b1);
      tail(0);

      // Enable dropped mid-left, restored mid-right.
      send_slot(0, 1'b1, rnd(DW0), DW0, 8, 1'b0);
      enable = 1'b0;
      send_slot(0, 1'b1, rnd(DW0), DW0, 8, 1'b0);
      send_slot(0, 1'b0, rnd(DW0), DW0, 8, 1'b0);
      enable = 1'b1;
      send_slot(0, 1'b0, rnd(DW0), DW0, 8, 1'b0);
      send_frame(0, rnd(DW0), rnd(DW0), 16, 17, 1'b1);
      tail(0);
      cmp("enable_no_error", 0, 96'(e0), 96'(0));

      // I2S, 24-bit words in 24..32-bit slots.
      send_slot(1, 1'b0, 32'h0, DW1, 4, 1'b0);
      send_frame(1, 32'h800000, 32'h7FFFFF, 32, 32, 1'b1);
      send_frame(1, rnd(DW1), rnd(DW1), 24, 24, 1'b1);
      repeat (5) send_frame(1, rnd(DW1), rnd(DW1), $urandom_range(24, 32), $urandom_range(24, 32), 1'b1);
      tail(1);
      cmp("frame_error_clean", 1, 96'(e1), 96'(0));
      send_frame(1, rnd(DW1), rnd(DW1), 32, 20, 1'b1);
      send_frame(1, rnd(DW1), rnd(DW1), 24, 28, 1'b1);
      tail(1);
      cmp("frame_error_set", 1, 96'(e1), 96'(1));

      repeat (20) @(posedge clk);
      #1;
      cmp("outputs_drained", 0, 96'(q0.size()), 96'(0));
      cmp("outputs_drained", 1, 96'(q1.size()), 96'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
